data_sram_responder: RTL
========================

Name: data_sram_responder

Overview:
Single-port, byte-enabled data SRAM that sits on the CPU's data-SRAM bus. It is the responder for the load/store requests issued from EX, and it returns read data consumed by MEM on the following cycle. It supports configurable wait states, signalled to the stall controller through stallreq_mem, so the pipeline can be run against slow-memory timing in simulation and on FPGA.

Parameters:
ADDR_W, 14, word-address width; capacity is 2^ADDR_W 32-bit words (64 KB at default)
WAIT, 0, stall cycles inserted per access; legal range 0..7

Ports:
clk  input  1  clock
rst  input  1  reset (see Behaviour)
data_sram_en  input  1  access request, held stable by the pipeline while stalled
data_sram_wen  input  4  byte write enables; 4'b0000 with en=1 means read
data_sram_addr  input  32  byte address
data_sram_wdata  input  32  store data, lane i = bits 8i+7:8i
data_sram_rdata  output  32  registered read data
stallreq_mem  output  1  combinational stall request to the stall controller

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset: state=IDLE, cnt=0, data_sram_rdata=0, stallreq_mem=0. Memory array is not cleared. Reset mid-wait abandons the pending access with no write and no rdata update.
- Word index = data_sram_addr[ADDR_W+1:2]. addr[1:0] and addr[31:ADDR_W+2] are ignored, so upper addresses alias.
- Commit: a write commit updates only the lanes whose wen bit is 1, at the clock edge. A read commit loads mem[index] into data_sram_rdata at the clock edge, so data is visible the cycle after commit.
- data_sram_rdata holds its value on write commits and idle cycles.
- FSM states: IDLE, WAITING. cnt is 3 bits.
- IDLE, en=0: stallreq_mem=0, no action.
- IDLE, en=1, WAIT=0: commit this cycle; stallreq_mem=0; stay in IDLE.
- IDLE, en=1, WAIT>0: stallreq_mem=1 (combinational, same cycle); cnt<=1; go to WAITING.
- WAITING, en=0 (request withdrawn): go to IDLE, cnt<=0, no commit, stallreq_mem=0.
- WAITING, en=1, cnt<WAIT: stallreq_mem=1; cnt<=cnt+1.
- WAITING, en=1, cnt==WAIT: stallreq_mem=0; commit; cnt<=0; go to IDLE.
- Net effect: exactly WAIT stall cycles per access. Commit occurs in the first cycle stallreq_mem is low with the request present.
- addr, wen and wdata are sampled only at commit. Changes during WAITING are not checked; the last value wins.
- Back-to-back requests: a new request seen in IDLE the cycle after a commit is a new access and incurs the full WAIT again.
- Read after write to the same word on consecutive commits returns the new data. Read-modify-write ordering is strict program order.
- No X propagation: an unwritten location reads as the simulator's init value. The bench must initialise memory with writes.

Test Plan:
- WAIT=0: write addr 0x10, wen 4'hF, data 0xDEADBEEF; next cycle read 0x10 -> rdata=0xDEADBEEF one cycle after the read; stallreq_mem never high.
- WAIT=0 byte lanes: word 0x20=0x11223344; write wen 4'b0010, data 0x0000AA00; read -> 0x1122AA44. Then write wen 4'b1000, data 0x55000000 -> read 0x5522AA44.
- WAIT=0 aliasing: write 0x00000104 = 0x12345678, read 0x00010104 (ADDR_W=14) -> 0x12345678; read of 0x00000107 -> same word.
- WAIT=3: read held 5 cycles -> stallreq_mem high exactly cycles 0..2, low on cycle 3 (commit), rdata valid cycle 4. Immediate next read -> stallreq_mem high again for 3 cycles.
- WAIT=2 abort: write request starts, en dropped in cycle 1 -> state IDLE, memory unchanged (read-back shows old value), stallreq_mem=0. Same scenario with rst asserted in cycle 1 instead -> rdata=0, stallreq_mem=0, no write.
- WAIT=2 write-then-read of the same word back-to-back -> the read returns the written value after its own 2 stall cycles; no stale data.

Source files
------------

// File: rtl/data_sram_responder.sv
// Byte-enabled single-port data SRAM responder for the CPU data-SRAM bus.
// Optional wait states stretch each access and are reported through stallreq_mem.
module data_sram_responder #(
  parameter int ADDR_W = 14,
  parameter int WAIT   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_mem
);

  typedef enum logic {IDLE, WAITING} state_t;

  localparam logic [2:0] WAIT_CNT = 3'(WAIT);

  state_t            state;
  logic [2:0]        cnt;
  logic              commit;
  logic [ADDR_W-1:0] index;
  logic [31:0]       mem [2**ADDR_W];

  // Byte offset and high address bits are ignored, so upper addresses alias.
  assign index = data_sram_addr[ADDR_W+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  // Commit happens in the first cycle the request is present with no stall left.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    stallreq_mem = 1'b0;
    commit       = 1'b0;
    if (!rst && data_sram_en) begin
      if (state == IDLE) begin
        if (WAIT_CNT == 3'd0) commit = 1'b1;
        else                  stallreq_mem = 1'b1;
      end else if (cnt < WAIT_CNT) begin
        stallreq_mem = 1'b1;
      end else begin
        commit = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= 3'd0;
      data_sram_rdata <= 32'd0;
    end else begin
      if (commit && data_sram_wen == 4'b0000) data_sram_rdata <= mem[index];
      case (state)
        IDLE: begin
          if (data_sram_en && WAIT_CNT != 3'd0) begin
            state <= WAITING;
            cnt   <= 3'd1;
          end
        end
        WAITING: begin
          if (!data_sram_en || cnt >= WAIT_CNT) begin
            state <= IDLE;
            cnt   <= 3'd0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

  // NOTE: the memory array has no reset; clearing it would defeat RAM inference.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wen[b]) mem[index][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

endmodule
